data_memory_banked: RTL and testbench
=====================================

DATA_MEMORY_BANKED -- requirements
Module: data_memory_banked

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32: word width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter NUM_WORDS, default 32: memory depth in words.
REQ-003 The block SHALL have parameter NB_ADDR, default $clog2(NUM_WORDS*NB_DATA/8): width of the byte address.
REQ-004 The block SHALL have parameter PROTECT_BYTES, default 4: byte addresses below this value are write-protected.
REQ-005 The block SHALL have port i_clock  in  1: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port i_reset  in  1: asynchronous, active-low reset.
REQ-007 The block SHALL have port i_clear  in  1: one-cycle request to zero the whole array.
REQ-008 The block SHALL have ports i_read_enable and i_write_enable  in  1 each: access strobes.
REQ-009 The block SHALL have port i_size  in  2: access size as log2 of the byte count (0 byte, 1 half, 2 word, 3 double); 3 is legal only when NB_DATA=64.
REQ-010 The block SHALL have port i_unsigned  in  1: load zero-extends when 1 and sign-extends when 0.
REQ-011 The block SHALL have ports i_address  in  NB_ADDR (byte address) and i_data_write  in  NB_DATA (store data, right-justified).
REQ-012 The block SHALL have ports o_data_read  out  NB_DATA and o_read_valid  out  1: load result and its one-cycle qualifier.
REQ-013 The block SHALL have ports o_misaligned and o_protect_violation  out  1 each: one-cycle error pulses.
REQ-014 The block SHALL have port o_busy  out  1: high while the clear sweep runs.
REQ-015 The block SHALL have ports i_debug_read_mem_address  in  NB_ADDR and o_debug_read_mem  out  NB_DATA: word-granular debug read.

Function
REQ-016 Storage SHALL be NUM_WORDS words of NB_DATA bits with per-byte write enables; word index = i_address >> log2(NB_DATA/8); byte lane = the low address bits.
REQ-017 The access is aligned iff i_address mod 2^i_size = 0; i_size=3 with NB_DATA=32 SHALL be treated as misaligned.
REQ-018 An aligned store SHALL write the low 2^i_size bytes of i_data_write into lanes [lane, lane+2^i_size-1] and leave every other byte unchanged.
REQ-019 A store to byte address < PROTECT_BYTES SHALL be dropped and SHALL pulse o_protect_violation one cycle later.
REQ-020 A misaligned read or write SHALL be dropped, SHALL pulse o_misaligned one cycle later, and a misaligned read SHALL return 0 with o_read_valid=1.
REQ-021 An aligned load SHALL register the addressed bytes, right-justified and extended per i_unsigned, into o_data_read, with o_read_valid=1 exactly one cycle after the strobe.
REQ-022 When no load completes, o_read_valid SHALL be 0 and o_data_read SHALL hold its last value.
REQ-023 A read and a write to the same word in the same cycle SHALL return the old data (read-before-write).
REQ-024 Asserting i_read_enable and i_write_enable together SHALL perform both operations.
REQ-025 The FSM SHALL have two states, S_CLEAR and S_IDLE; S_CLEAR writes zero to word clr_cnt each cycle and increments clr_cnt from 0 to NUM_WORDS-1.
REQ-026 S_CLEAR SHALL move to S_IDLE after writing word NUM_WORDS-1, so the sweep takes exactly NUM_WORDS cycles.
REQ-027 i_clear in S_IDLE SHALL move the FSM to S_CLEAR with clr_cnt=0; i_clear in S_CLEAR SHALL be ignored.
REQ-028 o_busy SHALL equal (state==S_CLEAR).
REQ-029 While o_busy=1, read and write strobes SHALL be ignored: no valid, no error pulses, no array write.
REQ-030 o_debug_read_mem SHALL register the word at i_debug_read_mem_address (low lane bits ignored) one cycle later, independent of o_busy.

Reset
REQ-031 When i_reset=0, the block SHALL immediately force state=S_CLEAR, clr_cnt=0, o_data_read=0, o_read_valid=0, o_misaligned=0, o_protect_violation=0, o_debug_read_mem=0 and o_busy=1.
REQ-032 The array SHALL NOT be reset directly; the sweep SHALL start on the first rising edge after i_reset rises.
REQ-033 A reset asserted mid-sweep SHALL restart the sweep from word 0.

Structure
REQ-034 The package mem_pkg SHALL hold the size encodings SZ_BYTE, SZ_HALF, SZ_WORD and SZ_DOUBLE and the FSM state constants.
REQ-035 The block SHALL contain one sub-module, mem_lane_align, a combinational unit that computes the byte mask, the store shift, the load extract/extend and the alignment flag.

Verification
REQ-036 Reset, then count cycles -> o_busy=1 for exactly 32 cycles; afterwards a word read of address 0x10 returns 0x00000000.
REQ-037 Store word 0xDEADBEEF @0x08, then load byte signed @0x0B, then load byte unsigned @0x0B -> 0xFFFFFFDE then 0x000000DE, each with o_read_valid one cycle after its strobe.
REQ-038 Store half 0x1234 @0x0C over a word holding 0xAABBCCDD -> a word read of 0x0C returns 0xAABB1234.
REQ-039 Store word @0x0A and store byte @0x02 -> o_misaligned pulse and o_protect_violation pulse respectively, with memory unchanged.
REQ-040 i_clear, then a write during the sweep, then reset asserted mid-sweep -> the write is ignored, the sweep restarts, and o_busy falls exactly 32 cycles after reset release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the banked data memory: access sizes and FSM states.
package mem_pkg;

   // Access size as log2 of the byte count
   localparam logic [1:0] SZ_BYTE   = 2'd0;
   localparam logic [1:0] SZ_HALF   = 2'd1;
   localparam logic [1:0] SZ_WORD   = 2'd2;
   localparam logic [1:0] SZ_DOUBLE = 2'd3;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte-enable mask, store shift, load
// extract/extend and the alignment flag for one access.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int NB_DATA = 32,
   localparam int NB_BYTES = NB_DATA / 8,
   localparam int LANE_W   = $clog2(NB_BYTES)
) (
   input  logic [1:0]          i_size,
   input  logic [LANE_W-1:0]   i_lane,
   input  logic                i_unsigned,
   input  logic [NB_DATA-1:0]  i_store_data,
   input  logic [NB_DATA-1:0]  i_read_word,
   output logic [NB_BYTES-1:0] o_byte_mask,
   output logic [NB_DATA-1:0]  o_store_data,
   output logic [NB_DATA-1:0]  o_load_data,
   output logic                o_aligned
);

   logic [NB_DATA-1:0]  shifted;
   logic [NB_DATA-1:0]  low_mask;
   logic [NB_BYTES-1:0] size_mask;
   logic                sign_bit;

   // Decode size into masks, pick the sign bit and judge alignment
   always_comb begin
      shifted   = i_read_word >> {i_lane, 3'b000};
      low_mask  = '0;
      size_mask = '0;
      sign_bit  = 1'b0;
      o_aligned = 1'b0;
      case (i_size)
         SZ_BYTE: begin
            low_mask  = NB_DATA'(8'hFF);
            size_mask = NB_BYTES'(1'b1);
            sign_bit  = shifted[7];
            o_aligned = 1'b1;
         end
         SZ_HALF: begin
            low_mask  = NB_DATA'(16'hFFFF);
            size_mask = NB_BYTES'(2'b11);
            sign_bit  = shifted[15];
            o_aligned = (i_lane[0] == 1'b0);
         end
         SZ_WORD: begin
            low_mask  = NB_DATA'(32'hFFFF_FFFF);
            size_mask = NB_BYTES'(4'hF);
            sign_bit  = shifted[31];
            o_aligned = (i_lane[1:0] == 2'b00);
         end
         default: begin
            // A double only exists on a 64-bit array; otherwise it can never align
            if (NB_DATA == 64) begin
               low_mask  = '1;
               size_mask = '1;
               sign_bit  = shifted[NB_DATA-1];
               o_aligned = (i_lane == '0);
            end
         end
      endcase
   end

   // Steer store bytes into their lanes and extend the loaded field
   always_comb begin
      o_byte_mask  = o_aligned ? (size_mask << i_lane) : '0;
      o_store_data = i_store_data << {i_lane, 3'b000};
      o_load_data  = '0;
      if (o_aligned) begin
         o_load_data = (shifted & low_mask)
                     | ((sign_bit && !i_unsigned) ? ~low_mask : '0);
      end
   end

endmodule

// File: rtl/data_memory_banked.sv
// Byte-addressable data memory with sized/extended loads, write protection
// of the low bytes, misalignment detection and a zeroing sweep after reset
// or on request.
//
//   state   | meaning
//   S_CLEAR | sweep writing zero to word clr_cnt, accesses ignored, o_busy=1
//   S_IDLE  | normal load/store service
module data_memory_banked
   import mem_pkg::*;
#(
   parameter int NB_DATA       = 32,
   parameter int NUM_WORDS     = 32,
   parameter int NB_ADDR       = $clog2(NUM_WORDS * NB_DATA / 8),
   parameter int PROTECT_BYTES = 4
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_clear,
   input  logic               i_read_enable,
   input  logic               i_write_enable,
   input  logic [1:0]         i_size,
   input  logic               i_unsigned,
   input  logic [NB_ADDR-1:0] i_address,
   input  logic [NB_DATA-1:0] i_data_write,
   output logic [NB_DATA-1:0] o_data_read,
   output logic               o_read_valid,
   output logic               o_misaligned,
   output logic               o_protect_violation,
   output logic               o_busy,
   input  logic [NB_ADDR-1:0] i_debug_read_mem_address,
   output logic [NB_DATA-1:0] o_debug_read_mem
);

   localparam int NB_BYTES = NB_DATA / 8;
   localparam int LANE_W   = $clog2(NB_BYTES);
   localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   logic [NB_DATA-1:0]  mem [NUM_WORDS];

   mem_state_t          state, state_nxt;
   logic [IDX_W-1:0]    clr_cnt;
   logic                clr_we;
   logic                clr_last;

   logic [IDX_W-1:0]    word_idx;
   logic [IDX_W-1:0]    dbg_idx;
   logic [LANE_W-1:0]   lane;
   logic [NB_DATA-1:0]  read_word;
   logic [NB_BYTES-1:0] byte_mask;
   logic [NB_DATA-1:0]  store_data;
   logic [NB_DATA-1:0]  load_data;
   logic                aligned;
   logic                rd_go, wr_go;
   logic                protect_hit;
   logic                store_ok;

   assign word_idx  = i_address[LANE_W +: IDX_W];
   assign dbg_idx   = i_debug_read_mem_address[LANE_W +: IDX_W];
   assign lane      = i_address[LANE_W-1:0];
   assign read_word = mem[word_idx];
   assign clr_last  = (clr_cnt == IDX_W'(NUM_WORDS - 1));

   mem_lane_align #(
      .NB_DATA (NB_DATA)
   ) u_align (
      .i_size       (i_size),
      .i_lane       (lane),
      .i_unsigned   (i_unsigned),
      .i_store_data (i_data_write),
      .i_read_word  (read_word),
      .o_byte_mask  (byte_mask),
      .o_store_data (store_data),
      .o_load_data  (load_data),
      .o_aligned    (aligned)
   );

   // State register; reset restarts the sweep
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) state <= S_CLEAR;
      else          state <= state_nxt;
   end

   // Next state: sweep ends after the last word, i_clear starts a new one
   always_comb begin
      state_nxt = state;
      case (state)
         S_CLEAR: if (clr_last) state_nxt = S_IDLE;
         S_IDLE:  if (i_clear)  state_nxt = S_CLEAR;
         default: state_nxt = S_CLEAR;
      endcase
   end

   // FSM outputs
   always_comb begin
      o_busy = (state == S_CLEAR);
      clr_we = (state == S_CLEAR);
   end

   // Sweep pointer: walks the array in S_CLEAR, parked at 0 otherwise
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)                  clr_cnt <= '0;
      else if (state == S_CLEAR)     clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      else                           clr_cnt <= '0;
   end

   // Access qualification; everything is ignored during the sweep
   always_comb begin
      rd_go       = i_read_enable  && !o_busy;
      wr_go       = i_write_enable && !o_busy;
      protect_hit = (32'(i_address) < PROTECT_BYTES);
      store_ok    = wr_go && aligned && !protect_hit;
   end

   // Array write port: sweep has priority, stores use per-byte enables
   always_ff @(posedge i_clock) begin
      if (clr_we) begin
         mem[clr_cnt] <= '0;
      end else if (store_ok) begin
         for (int b = 0; b < NB_BYTES; b++) begin
            if (byte_mask[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
         end
      end
   end

   // Registered load result, status pulses and debug read
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         o_data_read         <= '0;
         o_read_valid        <= 1'b0;
         o_misaligned        <= 1'b0;
         o_protect_violation <= 1'b0;
         o_debug_read_mem    <= '0;
      end else begin
         o_read_valid        <= rd_go;
         o_misaligned        <= (rd_go || wr_go) && !aligned;
         o_protect_violation <= wr_go && protect_hit;
         if (rd_go) o_data_read <= load_data;
         o_debug_read_mem    <= mem[dbg_idx];
      end
   end

endmodule

// File: tb/tb_data_memory_banked.sv
module tb_data_memory_banked;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        rd_en, wr_en;
   logic [1:0]  sz;
   logic        uns;
   logic [6:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid, mis, prot, busy;
   logic [6:0]  dbg_addr;
   logic [31:0] dbg_data;

   int vectors     = 0;
   int miscompares = 0;
   int n;

   always #5 clk = ~clk;

   data_memory_banked #(
      .NB_DATA       (32),
      .NUM_WORDS     (32),
      .NB_ADDR       (7),
      .PROTECT_BYTES (4)
   ) dut (
      .i_clock                  (clk),
      .i_reset                  (rst_n),
      .i_clear                  (clr),
      .i_read_enable            (rd_en),
      .i_write_enable           (wr_en),
      .i_size                   (sz),
      .i_unsigned               (uns),
      .i_address                (addr),
      .i_data_write             (wdata),
      .o_data_read              (rdata),
      .o_read_valid             (rvalid),
      .o_misaligned             (mis),
      .o_protect_violation      (prot),
      .o_busy                   (busy),
      .i_debug_read_mem_address (dbg_addr),
      .o_debug_read_mem         (dbg_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one access at a negedge; it is captured by the next posedge and
   // its registered results are visible at the following negedge.
   task automatic op(input logic rd, input logic wr, input logic [1:0] s,
                     input logic u, input logic [6:0] a, input logic [31:0] d);
      rd_en = rd; wr_en = wr; sz = s; uns = u; addr = a; wdata = d;
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b1; clr = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
      sz = SZ_WORD; uns = 1'b0; addr = '0; wdata = '0; dbg_addr = '0;

      // Asynchronous reset values
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy",   busy,   1'b1);
      chk("rst_valid",  rvalid, 1'b0);
      chk("rst_rdata",  rdata,  32'h0);
      chk("rst_mis",    mis,    1'b0);
      chk("rst_prot",   prot,   1'b0);
      chk("rst_dbg",    dbg_data, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      count_busy(n);
      chk("sweep_len", n, 32);

      op(1, 0, SZ_WORD, 0, 7'h10, 0);
      chk("rd10_valid", rvalid, 1'b1);
      chk("rd10_data",  rdata,  32'h0);

      // Store word, sized/extended loads
      op(0, 1, SZ_WORD, 0, 7'h08, 32'hDEAD_BEEF);
      chk("st08_valid", rvalid, 1'b0);
      chk("st08_mis",   mis,    1'b0);
      op(1, 0, SZ_BYTE, 0, 7'h0B, 0);
      chk("lb0B_valid", rvalid, 1'b1);
      chk("lb0B_data",  rdata,  32'hFFFF_FFDE);
      @(negedge clk);
      chk("idle_valid", rvalid, 1'b0);
      chk("idle_hold",  rdata,  32'hFFFF_FFDE);
      op(1, 0, SZ_BYTE, 1, 7'h0B, 0);
      chk("lbu0B_valid", rvalid, 1'b1);
      chk("lbu0B_data",  rdata,  32'h0000_00DE);
      op(1, 0, SZ_HALF, 0, 7'h0A, 0);
      chk("lh0A",  rdata, 32'hFFFF_DEAD);
      op(1, 0, SZ_HALF, 1, 7'h08, 0);
      chk("lhu08", rdata, 32'h0000_BEEF);
      op(1, 0, SZ_BYTE, 0, 7'h09, 0);
      chk("lb09",  rdata, 32'hFFFF_FFBE);
      op(1, 0, SZ_BYTE, 1, 7'h0A, 0);
      chk("lbu0A", rdata, 32'h0000_00AD);
      op(1, 0, SZ_HALF, 0, 7'h08, 0);
      chk("lh08",  rdata, 32'hFFFF_BEEF);

      // Partial stores leave other bytes untouched
      op(0, 1, SZ_WORD, 0, 7'h0C, 32'hAABB_CCDD);
      op(0, 1, SZ_HALF, 0, 7'h0C, 32'hFFFF_1234);
      op(1, 0, SZ_WORD, 0, 7'h0C, 0);
      chk("sh0C", rdata, 32'hAABB_1234);
      op(0, 1, SZ_BYTE, 0, 7'h0F, 32'hFFFF_FF55);
      op(1, 0, SZ_WORD, 0, 7'h0C, 0);
      chk("sb0F", rdata, 32'h55BB_1234);

      // Misaligned store and protected store are dropped
      op(0, 1, SZ_WORD, 0, 7'h0A, 32'h1111_1111);
      chk("mis_st_mis",  mis,  1'b1);
      chk("mis_st_prot", prot, 1'b0);
      @(negedge clk);
      chk("mis_pulse_end", mis, 1'b0);
      op(1, 0, SZ_WORD, 0, 7'h08, 0);
      chk("mis_st_mem", rdata, 32'hDEAD_BEEF);
      op(0, 1, SZ_BYTE, 0, 7'h02, 32'h0000_0077);
      chk("prot_prot", prot, 1'b1);
      chk("prot_mis",  mis,  1'b0);
      @(negedge clk);
      chk("prot_pulse_end", prot, 1'b0);
      op(1, 0, SZ_WORD, 0, 7'h00, 0);
      chk("prot_mem", rdata, 32'h0);
      op(0, 1, SZ_BYTE, 0, 7'h04, 32'h0000_0099);
      chk("prot_edge_prot", prot, 1'b0);
      op(1, 0, SZ_WORD, 0, 7'h04, 0);
      chk("prot_edge_mem", rdata, 32'h0000_0099);

      // Misaligned loads return zero with valid
      op(1, 0, SZ_WORD, 0, 7'h0E, 0);
      chk("mis_ld_valid", rvalid, 1'b1);
      chk("mis_ld_mis",   mis,    1'b1);
      chk("mis_ld_data",  rdata,  32'h0);
      op(1, 0, SZ_HALF, 0, 7'h0A, 0);
      op(1, 0, SZ_DOUBLE, 0, 7'h08, 0);
      chk("dbl_mis",  mis,   1'b1);
      chk("dbl_data", rdata, 32'h0);

      // Read-before-write on the same word
      op(1, 1, SZ_WORD, 0, 7'h08, 32'hCAFE_F00D);
      chk("rbw_old", rdata, 32'hDEAD_BEEF);
      op(1, 0, SZ_WORD, 0, 7'h08, 0);
      chk("rbw_new", rdata, 32'hCAFE_F00D);

      // Debug port ignores lane bits
      dbg_addr = 7'h0E;
      @(negedge clk);
      chk("dbg_0E", dbg_data, 32'h55BB_1234);

      // Clear sweep: accesses ignored, reset mid-sweep restarts it
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_busy", busy, 1'b1);
      repeat (8) @(negedge clk);
      op(1, 1, SZ_WORD, 0, 7'h10, 32'h1234_5678);
      chk("sweep_valid", rvalid, 1'b0);
      chk("sweep_mis",   mis,    1'b0);
      chk("sweep_rdata", rdata,  32'hCAFE_F00D);
      dbg_addr = 7'h10;
      @(negedge clk);
      chk("sweep_dbg", dbg_data, 32'h0);
      chk("sweep_still_busy", busy, 1'b1);
      op(0, 1, SZ_BYTE, 0, 7'h02, 32'h0000_0077);
      chk("sweep_prot", prot, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy",  busy,  1'b1);
      chk("midrst_rdata", rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      count_busy(n);
      chk("resweep_len", n, 32);
      op(1, 0, SZ_WORD, 0, 7'h0C, 0);
      chk("cleared_valid", rvalid, 1'b1);
      chk("cleared_0C",    rdata,  32'h0);
      op(1, 0, SZ_WORD, 0, 7'h08, 0);
      chk("cleared_08",    rdata,  32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
